pit_program_sequencer: RTL and testbench

- Sequences writes into the limited-function 8253 timer (mode-3 square-wave generator, three channels) on behalf of three independent requesters, one per timer channel.
- Each request carries a 16-bit divisor. The block round-robin arbitrates between requests and issues the write sequence on the timer's byte-write bus: control word, then LSB, then MSB.
- Drives the timer's per-channel gate inputs. The gate of a channel is held low while that channel is being reprogrammed, so no partial-divisor output glitches reach downstream logic.

---
 rtl/pit_program_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_pit_program_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_program_sequencer.sv
// -----------------------------------------------------------------------------
// pit_program_sequencer
//
// Programs a mode-3 8253-style timer on behalf of three requesters, one per
// timer channel. Requests are arbitrated round-robin. For each grant the block
// writes three bytes on the timer's byte-write bus: the control word, then the
// divisor LSB, then the divisor MSB. The gate of the channel being programmed
// is held low for the whole write sequence, so the timer never runs on a
// half-written divisor.
//
// Ports
//   clk       in   system clock, shared with the timer's write-detect logic
//   reset     in   synchronous, active-high reset
//   req[2:0]  in   level-sensitive program request, bit i -> channel i
//   div0..2   in   16-bit divisors, sampled at grant
//   run[2:0]  in   requested gate level per channel
//   ack[2:0]  out  one-cycle completion pulse for the programmed channel
//   busy      out  high while a write sequence is in progress
//   pit_adr   out  timer register address (3 = control word register)
//   pit_din   out  timer write data
//   pit_wr    out  timer write strobe, high for exactly one cycle per byte
//   pit_gate  out  timer gate inputs
//
// All outputs are registered. They are decoded from the next state so that
// each output changes in the same cycle the FSM enters the matching state.
// -----------------------------------------------------------------------------
module pit_program_sequencer #(
    parameter logic [2:0]  CW_MODE      = 3'b011,
    parameter int unsigned WR_LO_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] div0,
    input  logic [15:0] div1,
    input  logic [15:0] div2,
    input  logic [2:0]  run,
    output logic [2:0]  ack,
    output logic        busy,
    output logic [1:0]  pit_adr,
    output logic [7:0]  pit_din,
    output logic        pit_wr,
    output logic [2:0]  pit_gate
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CW_HI  = 3'd1,
        CW_LO  = 3'd2,
        LSB_HI = 3'd3,
        LSB_LO = 3'd4,
        MSB_HI = 3'd5,
        MSB_LO = 3'd6,
        DONE   = 3'd7
    } state_t;

    // Last count value of a LO state; the LO state lasts WR_LO_CYCLES cycles.
    localparam logic [3:0] LO_LAST = 4'(WR_LO_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] dv_q, dv_d;
    logic [1:0]  rr_q, rr_d;

    logic [2:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [1:0]  adr_q, adr_d;
    logic [7:0]  din_q, din_d;
    logic        wr_q, wr_d;
    logic [2:0]  gate_q, gate_d;

    logic [1:0]  grant_s;
    logic [15:0] div_sel_s;

    // Round-robin pick: search upward from the channel after the last one served.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (r[first]) begin
            rr_pick = first;
        end else if (r[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    // Mode 3 needs a divisor of at least 2; smaller values are forced to 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        if (d < 16'd2) begin
            clamp_div = 16'd2;
        end else begin
            clamp_div = d;
        end
    endfunction

    // Grant candidate and its divisor.
    always_comb begin
        grant_s = rr_pick(rr_q, req);
        case (grant_s)
            2'd0:    div_sel_s = div0;
            2'd1:    div_sel_s = div1;
            default: div_sel_s = div2;
        endcase
    end

    // Next-state logic: arbitration, sequencing and LO-phase timing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        dv_d    = dv_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    ch_d    = grant_s;
                    dv_d    = clamp_div(div_sel_s);
                    state_d = CW_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            CW_HI: begin
                cnt_d   = 4'd0;
                state_d = CW_LO;
            end
            CW_LO: begin
                if (cnt_q == LO_LAST) begin
                    state_d = LSB_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LSB_HI: begin
                cnt_d   = 4'd0;
                state_d = LSB_LO;
            end
            LSB_LO: begin
                if (cnt_q == LO_LAST) begin
                    state_d = MSB_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            MSB_HI: begin
                cnt_d   = 4'd0;
                state_d = MSB_LO;
            end
            MSB_LO: begin
                if (cnt_q == LO_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                rr_d    = ch_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state; LO and IDLE states hold address/data.
    always_comb begin
        wr_d   = 1'b0;
        adr_d  = adr_q;
        din_d  = din_q;
        ack_d  = 3'b000;
        busy_d = (state_d != IDLE);
        gate_d = run;
        case (state_d)
            CW_HI: begin
                adr_d        = 2'b11;
                din_d        = {ch_d, 2'b11, CW_MODE, 1'b0};
                wr_d         = 1'b1;
                gate_d[ch_d] = 1'b0;
            end
            LSB_HI: begin
                adr_d        = ch_d;
                din_d        = dv_d[7:0];
                wr_d         = 1'b1;
                gate_d[ch_d] = 1'b0;
            end
            MSB_HI: begin
                adr_d        = ch_d;
                din_d        = dv_d[15:8];
                wr_d         = 1'b1;
                gate_d[ch_d] = 1'b0;
            end
            CW_LO, LSB_LO, MSB_LO: begin
                gate_d[ch_d] = 1'b0;
            end
            DONE: begin
                adr_d       = 2'b11;
                din_d       = 8'h00;
                ack_d[ch_d] = 1'b1;
            end
            IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ch_q    <= 2'd0;
            dv_q    <= 16'h0000;
            rr_q    <= 2'd2;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
            adr_q   <= 2'b11;
            din_q   <= 8'h00;
            wr_q    <= 1'b0;
            gate_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            dv_q    <= dv_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            gate_q  <= gate_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign pit_adr  = adr_q;
    assign pit_din  = din_q;
    assign pit_wr   = wr_q;
    assign pit_gate = gate_q;

endmodule

// File: tb/tb_pit_program_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for pit_program_sequencer. A transaction-level reference model
// tracks the position inside the current write sequence as a cycle offset and
// derives every expected output from that offset arithmetically.
// -----------------------------------------------------------------------------
module tb_pit_program_sequencer;

    localparam int LO = 1;
    localparam int P  = 1 + LO;     // cycles per byte
    localparam int L  = 3 * P + 1;  // offset of the DONE cycle

    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic [2:0]  req, req_b, run;
    logic [15:0] divs [3];

    logic [2:0]  ack, ack_b;
    logic        busy, busy_b;
    logic [1:0]  pit_adr, pit_adr_b;
    logic [7:0]  pit_din, pit_din_b;
    logic        pit_wr, pit_wr_b;
    logic [2:0]  pit_gate, pit_gate_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_t;
    int          m_ch;
    int          m_rr;
    logic [15:0] m_dv;
    logic        e_wr, e_busy;
    logic [1:0]  e_adr;
    logic [7:0]  e_din;
    logic [2:0]  e_gate, e_ack;

    always #5 clk = ~clk;

    pit_program_sequencer #(.CW_MODE(3'b011), .WR_LO_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .req(req),
        .div0(divs[0]), .div1(divs[1]), .div2(divs[2]), .run(run),
        .ack(ack), .busy(busy), .pit_adr(pit_adr), .pit_din(pit_din),
        .pit_wr(pit_wr), .pit_gate(pit_gate)
    );

    pit_program_sequencer #(.CW_MODE(3'b011), .WR_LO_CYCLES(3)) u_dut_b (
        .clk(clk), .reset(reset_b), .req(req_b),
        .div0(divs[0]), .div1(divs[1]), .div2(divs[2]), .run(run),
        .ack(ack_b), .busy(busy_b), .pit_adr(pit_adr_b), .pit_din(pit_din_b),
        .pit_wr(pit_wr_b), .pit_gate(pit_gate_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int b;
        if (reset) begin
            m_t = 0; m_rr = 2; m_ch = 0; m_dv = 16'h0000;
            e_wr = 1'b0; e_adr = 2'd3; e_din = 8'h00; e_gate = 3'b000;
            e_ack = 3'b000; e_busy = 1'b0;
            return;
        end
        if (m_t == 0) begin
            if (req != 3'b000) begin
                for (int k = 3; k >= 1; k--) begin
                    if (req[(m_rr + k) % 3]) m_ch = (m_rr + k) % 3;
                end
                m_dv = divs[m_ch];
                if (m_dv < 16'd2) m_dv = 16'd2;
                m_t = 1;
            end
        end else if (m_t == L) begin
            m_t = 0;
        end else begin
            m_t++;
        end
        e_busy = (m_t != 0);
        e_wr   = (m_t != 0) && (m_t < L) && (((m_t - 1) % P) == 0);
        e_ack  = 3'b000;
        if (m_t == 0 || m_t == L) begin
            e_adr = 2'd3;
            e_din = 8'h00;
        end else begin
            b = (m_t - 1) / P;
            if (b == 0) begin
                e_adr = 2'd3;
                e_din = 8'h36 + 8'(m_ch * 64);
            end else if (b == 1) begin
                e_adr = 2'(m_ch);
                e_din = m_dv[7:0];
            end else begin
                e_adr = 2'(m_ch);
                e_din = m_dv[15:8];
            end
        end
        if (m_t == L) begin
            e_ack = 3'b001 << m_ch;
            m_rr  = m_ch;
        end
        e_gate = run;
        if (m_t >= 1 && m_t < L) e_gate[m_ch] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("wr",   32'(pit_wr),   32'(e_wr));
        check("adr",  32'(pit_adr),  32'(e_adr));
        check("din",  32'(pit_din),  32'(e_din));
        check("ack",  32'(ack),      32'(e_ack));
        check("busy", 32'(busy),     32'(e_busy));
        check("gate", 32'(pit_gate), 32'(e_gate));
    endtask

    // Run requests until n acks are seen, each requester dropping on its ack.
    task automatic rr_run(input logic [2:0] r, input int n, input int exp_ch [3]);
        int cnt;
        cnt = 0;
        req = r;
        for (int cyc = 0; cyc < 40 && cnt < n; cyc++) begin
            step();
            if (pit_wr && pit_adr == 2'd3)
                check("rr_cw", 32'(pit_din), 32'(8'h36 + 8'(exp_ch[cnt] * 64)));
            if (ack != 3'b000) begin
                check("rr_order", 32'(ack), 32'(3'b001 << exp_ch[cnt]));
                req = req & ~ack;
                cnt++;
            end
        end
        check("rr_count", 32'(cnt), 32'(n));
        req = 3'b000;
        step();
    endtask

    typedef struct {
        int          ch;
        logic [15:0] div;
        logic [7:0]  cw;
        logic [7:0]  lsb;
        logic [7:0]  msb;
    } vec_t;

    vec_t vecs [6];
    int   pulses [$];
    logic [7:0] pulse_din [$];
    int   ack_at;

    initial begin
        vecs[0] = '{ch: 2, div: 16'h1234, cw: 8'hB6, lsb: 8'h34, msb: 8'h12};
        vecs[1] = '{ch: 0, div: 16'h0001, cw: 8'h36, lsb: 8'h02, msb: 8'h00};
        vecs[2] = '{ch: 1, div: 16'h0000, cw: 8'h76, lsb: 8'h02, msb: 8'h00};
        vecs[3] = '{ch: 0, div: 16'h0003, cw: 8'h36, lsb: 8'h03, msb: 8'h00};
        vecs[4] = '{ch: 1, div: 16'hABCD, cw: 8'h76, lsb: 8'hCD, msb: 8'hAB};
        vecs[5] = '{ch: 2, div: 16'h0002, cw: 8'hB6, lsb: 8'h02, msb: 8'h00};

        reset = 1'b1; reset_b = 1'b1;
        req = 3'b000; req_b = 3'b000; run = 3'b111;
        divs[0] = 16'h0000; divs[1] = 16'h0000; divs[2] = 16'h0000;

        // reset and idle
        step();
        step();
        check("reset_wr", 32'(pit_wr), 32'd0);
        check("reset_adr", 32'(pit_adr), 32'd3);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        check("gate_after_reset", 32'(pit_gate), 32'h7);
        step();

        // single-channel write sequences
        for (int v = 0; v < 6; v++) begin
            divs[vecs[v].ch] = vecs[v].div;
            req = 3'b001 << vecs[v].ch;
            for (int s = 1; s <= 7; s++) begin
                step();
                if (s == 1) begin
                    req = 3'b000;
                    check("vec_cw_adr", 32'(pit_adr), 32'd3);
                    check("vec_cw", 32'(pit_din), 32'(vecs[v].cw));
                end
                if (s == 3) check("vec_lsb", 32'(pit_din), 32'(vecs[v].lsb));
                if (s == 5) check("vec_msb", 32'(pit_din), 32'(vecs[v].msb));
                if (s == 1 || s == 3 || s == 5) check("vec_wr", 32'(pit_wr), 32'd1);
                if (s < 7) check("vec_gate_low", 32'(pit_gate[vecs[v].ch]), 32'd0);
                if (s == 7) begin
                    check("vec_ack", 32'(ack), 32'(3'b001 << vecs[v].ch));
                    check("vec_gate_back", 32'(pit_gate[vecs[v].ch]), 32'd1);
                end
            end
            step();
        end

        // round-robin ordering
        divs[0] = 16'h0100; divs[1] = 16'h0200; divs[2] = 16'h0300;
        rr_run(3'b111, 3, '{0, 1, 2});
        rr_run(3'b010, 1, '{1, 0, 0});
        rr_run(3'b011, 2, '{0, 1, 0});
        rr_run(3'b110, 2, '{2, 1, 0});

        // reset during LSB_LO
        divs[0] = 16'h5555;
        req = 3'b001;
        for (int s = 1; s <= 4; s++) step();
        req = 3'b000;
        reset = 1'b1;
        step();
        check("midreset_wr", 32'(pit_wr), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        for (int s = 0; s < 6; s++) begin
            step();
            check("no_write_after_reset", 32'(pit_wr), 32'd0);
        end
        req = 3'b001;
        step();
        req = 3'b000;
        check("restart_wr", 32'(pit_wr), 32'd1);
        check("restart_cw", 32'(pit_din), 32'h36);
        for (int s = 0; s < 7; s++) step();

        // randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    if (e_ack[i]) req[i] = 1'b0;
                    else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) divs[i] = 16'($urandom_range(0, 3));
                    else divs[i] = 16'($urandom);
                end
            end
            run = 3'($urandom);
        end
        req = 3'b000;
        run = 3'b111;
        for (int s = 0; s < 10; s++) step();

        // longer LO phase: pulses 4 cycles apart, ack at N+13
        step();
        reset_b = 1'b0;
        step();
        divs[0] = 16'h0203;
        req_b = 3'b001;
        ack_at = -1;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s == 1) req_b = 3'b000;
            if (pit_wr_b) begin
                pulses.push_back(s);
                pulse_din.push_back(pit_din_b);
            end
            if (ack_b != 3'b000 && ack_at < 0) ack_at = s;
        end
        check("lo3_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("lo3_pulse0", 32'(pulses[0]), 32'd1);
            check("lo3_pulse1", 32'(pulses[1]), 32'd5);
            check("lo3_pulse2", 32'(pulses[2]), 32'd9);
            check("lo3_din0", 32'(pulse_din[0]), 32'h36);
            check("lo3_din1", 32'(pulse_din[1]), 32'h03);
            check("lo3_din2", 32'(pulse_din[2]), 32'h02);
        end
        check("lo3_ack_at", 32'(ack_at), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
